// File: rtl/riscv_core_if.sv
// rtl/riscv_core_if.sv - debug tap bundle exposing the core's fetch/decode/register-read state
interface riscv_core_if;
  logic [31:0] pc_out_check;
  logic [31:0] instruction_check;
  logic [2:0]  alu_op_check;
  logic [31:0] register_data_out1_check;
  logic [31:0] register_data_out2_check;

  modport master (
    output pc_out_check,
    output instruction_check,
    output alu_op_check,
    output register_data_out1_check,
    output register_data_out2_check
  );

  modport slave (
    input pc_out_check,
    input instruction_check,
    input alu_op_check,
    input register_data_out1_check,
    input register_data_out2_check
  );
endinterface

// File: rtl/riscv_core.sv
// rtl/riscv_core.sv - single-cycle RV32I core executing R/I-type ALU instructions from a word ROM
// IMEM_INIT holds the ROM image, word n at bits [32n+31:32n].
module riscv_core #(
  parameter int IMEM_WORDS = 64,
  parameter logic [IMEM_WORDS*32-1:0] IMEM_INIT = {{((IMEM_WORDS-1)*32){1'b0}}, 32'h005303b3}
) (
  input logic         clk,
  input logic         reset,
  riscv_core_if.master dbg
);

  localparam int AW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_SRL = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  logic        run;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] rom [IMEM_WORDS];
  logic [31:0] regs [32];

  logic [6:0]  opcode;
  logic [4:0]  rd_idx;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] alu_b;
  logic [31:0] alu_res;
  logic [2:0]  alu_op;
  logic        wr_en;
  logic        use_imm;
  logic        f7_zero;
  logic        legal;

  for (genvar g = 0; g < IMEM_WORDS; g++) begin : g_rom
    assign rom[g] = IMEM_INIT[g*32 +: 32];
  end

  // Anything past the ROM image fetches an all-zero word, which decodes as a NOP.
  always_comb begin
    instr = 32'h0;
    if (pc[31:2] < 30'(IMEM_WORDS))
      instr = rom[pc[AW+1:2]];
  end

  assign opcode  = instr[6:0];
  assign rd_idx  = instr[11:7];
  assign funct3  = instr[14:12];
  assign rs1_idx = instr[19:15];
  assign rs2_idx = instr[24:20];
  assign funct7  = instr[31:25];
  assign imm_i   = {{20{instr[31]}}, instr[31:20]};
  assign f7_zero = (funct7 == 7'b0000000);
  assign use_imm = (opcode == OP_I);
  assign legal   = (opcode == OP_R) || use_imm;

  always_comb begin
    alu_op = ALU_ADD;
    wr_en  = 1'b0;
    if (legal) begin
      case (funct3)
        3'b000: begin
          if (use_imm || f7_zero) begin
            alu_op = ALU_ADD;
            wr_en  = 1'b1;
          end else if (funct7 == 7'b0100000) begin
            alu_op = ALU_SUB;
            wr_en  = 1'b1;
          end
        end
        3'b111: if (use_imm || f7_zero) begin alu_op = ALU_AND; wr_en = 1'b1; end
        3'b110: if (use_imm || f7_zero) begin alu_op = ALU_OR;  wr_en = 1'b1; end
        3'b100: if (use_imm || f7_zero) begin alu_op = ALU_XOR; wr_en = 1'b1; end
        3'b010: if (use_imm || f7_zero) begin alu_op = ALU_SLT; wr_en = 1'b1; end
        // Shift-immediates carry funct7 in imm[11:5]; a nonzero value (SRAI) is a NOP.
        3'b001: if (f7_zero) begin alu_op = ALU_SLL; wr_en = 1'b1; end
        3'b101: if (f7_zero) begin alu_op = ALU_SRL; wr_en = 1'b1; end
        default: ;
      endcase
    end
  end

  assign rd1   = (rs1_idx == 5'd0) ? 32'h0 : regs[rs1_idx];
  assign rd2   = (rs2_idx == 5'd0) ? 32'h0 : regs[rs2_idx];
  assign alu_b = use_imm ? imm_i : rd2;

  always_comb begin
    alu_res = 32'h0;
    case (alu_op)
      ALU_ADD: alu_res = rd1 + alu_b;
      ALU_SUB: alu_res = rd1 - alu_b;
      ALU_AND: alu_res = rd1 & alu_b;
      ALU_OR:  alu_res = rd1 | alu_b;
      ALU_XOR: alu_res = rd1 ^ alu_b;
      ALU_SLL: alu_res = rd1 << alu_b[4:0];
      ALU_SRL: alu_res = rd1 >> alu_b[4:0];
      ALU_SLT: alu_res = {31'b0, ($signed(rd1) < $signed(alu_b))};
      default: alu_res = 32'h0;
    endcase
  end

  // The edge that releases reset only arms the run flag; execution starts on the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run <= 1'b0;
      pc  <= 32'h0;
    end else begin
      run <= 1'b1;
      if (run)
        pc <= pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= 32'h0;
    end else if (run && wr_en && (rd_idx != 5'd0)) begin
      regs[rd_idx] <= alu_res;
    end
  end

  assign dbg.pc_out_check             = pc;
  assign dbg.instruction_check        = instr;
  assign dbg.alu_op_check             = alu_op;
  assign dbg.register_data_out1_check = rd1;
  assign dbg.register_data_out2_check = rd2;

endmodule

// File: tb/tb_riscv_core.sv
// tb/tb_riscv_core.sv - directed bench: default-ROM core plus a core running a preloaded ALU program
module tb_riscv_core;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  localparam logic [31:0] W0  = enc_i(12'd7,   5'd0,  3'b000, 5'd5);
  localparam logic [31:0] W1  = enc_i(12'hFFD, 5'd0,  3'b000, 5'd6);
  localparam logic [31:0] W2  = enc_r(7'h00, 5'd5,  5'd6,  3'b000, 5'd7);
  localparam logic [31:0] W3  = enc_r(7'h00, 5'd5,  5'd6,  3'b010, 5'd8);
  localparam logic [31:0] W4  = enc_r(7'h00, 5'd8,  5'd7,  3'b000, 5'd10);
  localparam logic [31:0] W5  = enc_i(12'hFF8, 5'd0,  3'b000, 5'd11);
  localparam logic [31:0] W6  = enc_i(12'd1,   5'd11, 3'b101, 5'd12);
  localparam logic [31:0] W7  = enc_i(12'd4,   5'd0,  3'b000, 5'd1);
  localparam logic [31:0] W8  = enc_i(12'd2,   5'd0,  3'b000, 5'd2);
  localparam logic [31:0] W9  = enc_r(7'h00, 5'd2,  5'd1,  3'b000, 5'd13);
  localparam logic [31:0] W10 = enc_r(7'h20, 5'd2,  5'd1,  3'b000, 5'd14);
  localparam logic [31:0] W11 = enc_r(7'h00, 5'd2,  5'd1,  3'b111, 5'd15);
  localparam logic [31:0] W12 = enc_r(7'h00, 5'd2,  5'd1,  3'b110, 5'd16);
  localparam logic [31:0] W13 = enc_r(7'h00, 5'd2,  5'd1,  3'b100, 5'd17);
  localparam logic [31:0] W14 = enc_r(7'h00, 5'd2,  5'd1,  3'b001, 5'd18);
  localparam logic [31:0] W15 = enc_r(7'h00, 5'd2,  5'd1,  3'b101, 5'd19);
  localparam logic [31:0] W16 = enc_r(7'h00, 5'd2,  5'd1,  3'b010, 5'd20);
  localparam logic [31:0] W17 = enc_r(7'h00, 5'd13, 5'd12, 3'b000, 5'd0);
  localparam logic [31:0] W18 = enc_r(7'h00, 5'd15, 5'd14, 3'b000, 5'd0);
  localparam logic [31:0] W19 = enc_r(7'h00, 5'd17, 5'd16, 3'b000, 5'd0);
  localparam logic [31:0] W20 = enc_r(7'h00, 5'd19, 5'd18, 3'b000, 5'd0);
  localparam logic [31:0] W21 = enc_r(7'h00, 5'd10, 5'd20, 3'b000, 5'd0);
  localparam logic [31:0] W22 = enc_i(12'd5,   5'd0,  3'b000, 5'd0);
  localparam logic [31:0] W23 = enc_r(7'h00, 5'd10, 5'd0,  3'b000, 5'd0);
  localparam logic [31:0] W24 = enc_r(7'h20, 5'd2,  5'd1,  3'b101, 5'd21);
  localparam logic [31:0] W25 = enc_r(7'h00, 5'd2,  5'd1,  3'b011, 5'd22);
  localparam logic [31:0] W26 = enc_i(12'hFFF, 5'd6,  3'b100, 5'd23);
  localparam logic [31:0] W27 = enc_r(7'h00, 5'd22, 5'd21, 3'b000, 5'd0);
  localparam logic [31:0] W28 = enc_r(7'h00, 5'd5,  5'd23, 3'b000, 5'd0);

  localparam int NPROG = 29;
  localparam logic [64*32-1:0] ROM_B = {{35{32'h0}},
    W28, W27, W26, W25, W24, W23, W22, W21, W20, W19, W18, W17, W16, W15,
    W14, W13, W12, W11, W10, W9, W8, W7, W6, W5, W4, W3, W2, W1, W0};

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  op;
    logic [31:0] rd1;
    logic [31:0] rd2;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   step;
  vec_t tbl [NPROG];

  riscv_core_if dbg_a ();
  riscv_core_if dbg_b ();

  riscv_core #(.IMEM_WORDS(64)) dut_a (
    .clk   (clk),
    .reset (reset),
    .dbg   (dbg_a)
  );

  riscv_core #(.IMEM_WORDS(64), .IMEM_INIT(ROM_B)) dut_b (
    .clk   (clk),
    .reset (reset),
    .dbg   (dbg_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h, expected %h", name, step, act, exp);
    end
  endtask

  task automatic chk_a(input logic [31:0] pc, input logic [31:0] instr);
    chk("a_pc",    dbg_a.pc_out_check, pc);
    chk("a_instr", dbg_a.instruction_check, instr);
    chk("a_aluop", {29'b0, dbg_a.alu_op_check}, 32'd0);
    chk("a_rd1",   dbg_a.register_data_out1_check, 32'h0);
    chk("a_rd2",   dbg_a.register_data_out2_check, 32'h0);
  endtask

  task automatic chk_b(input logic [31:0] pc, input vec_t v);
    chk("b_pc",    dbg_b.pc_out_check, pc);
    chk("b_instr", dbg_b.instruction_check, v.instr);
    chk("b_aluop", {29'b0, dbg_b.alu_op_check}, {29'b0, v.op});
    chk("b_rd1",   dbg_b.register_data_out1_check, v.rd1);
    chk("b_rd2",   dbg_b.register_data_out2_check, v.rd2);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    step   = -1;

    // Register values seen on the read ports before each program step executes.
    tbl[0]  = '{W0,  3'd0, 32'h0,        32'h0};
    tbl[1]  = '{W1,  3'd0, 32'h0,        32'h0};
    tbl[2]  = '{W2,  3'd0, 32'hFFFFFFFD, 32'd7};
    tbl[3]  = '{W3,  3'd7, 32'hFFFFFFFD, 32'd7};
    tbl[4]  = '{W4,  3'd0, 32'd4,        32'd1};
    tbl[5]  = '{W5,  3'd0, 32'h0,        32'h0};
    tbl[6]  = '{W6,  3'd6, 32'hFFFFFFF8, 32'h0};
    tbl[7]  = '{W7,  3'd0, 32'h0,        32'h0};
    tbl[8]  = '{W8,  3'd0, 32'h0,        32'h0};
    tbl[9]  = '{W9,  3'd0, 32'd4,        32'd2};
    tbl[10] = '{W10, 3'd1, 32'd4,        32'd2};
    tbl[11] = '{W11, 3'd2, 32'd4,        32'd2};
    tbl[12] = '{W12, 3'd3, 32'd4,        32'd2};
    tbl[13] = '{W13, 3'd4, 32'd4,        32'd2};
    tbl[14] = '{W14, 3'd5, 32'd4,        32'd2};
    tbl[15] = '{W15, 3'd6, 32'd4,        32'd2};
    tbl[16] = '{W16, 3'd7, 32'd4,        32'd2};
    tbl[17] = '{W17, 3'd0, 32'h7FFFFFFC, 32'd6};
    tbl[18] = '{W18, 3'd0, 32'd2,        32'd0};
    tbl[19] = '{W19, 3'd0, 32'd6,        32'd6};
    tbl[20] = '{W20, 3'd0, 32'd16,       32'd1};
    tbl[21] = '{W21, 3'd0, 32'd0,        32'd5};
    tbl[22] = '{W22, 3'd0, 32'd0,        32'd7};
    tbl[23] = '{W23, 3'd0, 32'd0,        32'd5};
    tbl[24] = '{W24, 3'd0, 32'd4,        32'd2};
    tbl[25] = '{W25, 3'd0, 32'd4,        32'd2};
    tbl[26] = '{W26, 3'd4, 32'hFFFFFFFD, 32'h0};
    tbl[27] = '{W27, 3'd0, 32'd0,        32'd0};
    tbl[28] = '{W28, 3'd0, 32'd2,        32'd7};

    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk_a(32'h0, 32'h005303b3);
    chk_b(32'h0, tbl[0]);

    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i <= 70; i++) begin
      @(negedge clk);
      step = i;
      chk_a(32'(i * 4), (i == 0) ? 32'h005303b3 : 32'h0);
      if (i < NPROG)
        chk_b(32'(i * 4), tbl[i]);
      else
        chk_b(32'(i * 4), '{32'h0, 3'd0, 32'h0, 32'h0});
    end

    // Mid-cycle reset pulse must clear PC and registers without waiting for an edge.
    step = 100;
    #2 reset = 1'b0;
    #1;
    chk_a(32'h0, 32'h005303b3);
    chk_b(32'h0, tbl[0]);

    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i <= 2; i++) begin
      @(negedge clk);
      step = 200 + i;
      chk_b(32'(i * 4), tbl[i]);
    end
    chk_a(32'd8, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
